// File: rtl/decoder_scan_ctrl_if.sv
// Control/status bundle between a scan sequencer and the 3-to-8 decoder select generator.
// skip_mask exists only when SCAN_SKIP_EN is defined.
interface decoder_scan_ctrl_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               mode_cont;
    logic [DWELL_W-1:0] dwell;
`ifdef SCAN_SKIP_EN
    logic [7:0]         skip_mask;
`endif
    logic               en;
    logic               A;
    logic               B;
    logic               C;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, mode_cont, dwell,
`ifdef SCAN_SKIP_EN
        output skip_mask,
`endif
        input  en, A, B, C, busy, done
    );

    modport slave (
        input  start, stop, mode_cont, dwell,
`ifdef SCAN_SKIP_EN
        input  skip_mask,
`endif
        output en, A, B, C, busy, done
    );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Channel scan generator driving the decoder en/A/B/C inputs, with dwell and blanking gap.
// Optional channel skipping is enabled by defining SCAN_SKIP_EN.
//
// state  | meaning
// IDLE   | en low, select 000, waiting for start
// ACTIVE | en high on the current channel for the latched dwell
// BLANK  | en low while the select already shows the next channel
module decoder_scan_ctrl #(
    parameter int DWELL_W   = 8,
    parameter int BLANK_CYC = 1
) (
    input logic                clk,
    input logic                rst_n,
    decoder_scan_ctrl_if.slave bus
);
    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;

    state_t             state_q, state_d;
    logic [2:0]         chan_q, chan_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [BW-1:0]      bcnt_q, bcnt_d;
    logic               mode_q, mode_d;
    logic               done_d;
    logic               en_q, busy_q, done_q;
    logic [DWELL_W-1:0] dwell_eff;
    logic               start_ok;

`ifdef SCAN_SKIP_EN
    logic [7:0] mask_q, mask_d, mask_in;
    assign mask_in = bus.skip_mask;
`else
    localparam logic [7:0] mask_q  = 8'h00;
    localparam logic [7:0] mask_in = 8'h00;
`endif

    function automatic logic [2:0] next_chan(input logic [2:0] cur, input logic [7:0] mask);
        logic [2:0] r;
        logic [2:0] idx;
        r = cur;
        // descending so the nearest unmasked channel above cur (with wrap) wins
        for (int k = 7; k >= 1; k--) begin
            idx = cur + 3'(k);
            if (!mask[idx]) r = idx;
        end
        return r;
    endfunction

    function automatic logic has_higher(input logic [2:0] cur, input logic [7:0] mask);
        logic h;
        h = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > int'(cur) && !mask[3'(i)]) h = 1'b1;
        end
        return h;
    endfunction

    function automatic logic [2:0] first_chan(input logic [7:0] mask);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!mask[3'(i)]) r = 3'(i);
        end
        return r;
    endfunction

    assign dwell_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
    assign start_ok  = bus.start && !bus.stop && (mask_in != 8'hFF);

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        dwell_d = dwell_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
`ifdef SCAN_SKIP_EN
        mask_d  = mask_q;
`endif
        case (state_q)
            IDLE: begin
                chan_d = 3'd0;
                if (start_ok) begin
                    dwell_d = dwell_eff;
                    mode_d  = bus.mode_cont;
`ifdef SCAN_SKIP_EN
                    mask_d  = mask_in;
`endif
                    chan_d  = first_chan(mask_in);
                    cnt_d   = dwell_eff - DWELL_W'(1);
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    chan_d  = 3'd0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (mode_q || has_higher(chan_q, mask_q)) begin
                    chan_d = next_chan(chan_q, mask_q);
                    if (BLANK_CYC > 0) begin
                        state_d = BLANK;
                        bcnt_d  = BW'(BLANK_CYC - 1);
                    end else begin
                        cnt_d = dwell_q - DWELL_W'(1);
                    end
                end else begin
                    state_d = IDLE;
                    chan_d  = 3'd0;
                    done_d  = 1'b1;
                end
            end
            BLANK: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    chan_d  = 3'd0;
                end else if (bcnt_q != '0) begin
                    bcnt_d = bcnt_q - BW'(1);
                end else begin
                    state_d = ACTIVE;
                    cnt_d   = dwell_q - DWELL_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                chan_d  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            chan_q  <= 3'd0;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            dwell_q <= '0;
            mode_q  <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SCAN_SKIP_EN
            mask_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            dwell_q <= dwell_d;
            mode_q  <= mode_d;
            en_q    <= (state_d == ACTIVE);
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
`ifdef SCAN_SKIP_EN
            mask_q  <= mask_d;
`endif
        end
    end

    assign bus.en   = en_q;
    assign bus.A    = chan_q[2];
    assign bus.B    = chan_q[1];
    assign bus.C    = chan_q[0];
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
